// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: takes a length-prefixed byte stream,
// assembles big-endian words and writes them to consecutive word addresses.
module imem_loader #(
  parameter int WORD_SIZE     = 32,
  parameter int MEM_SIZE      = 1024,
  parameter int MEM_CELL_SIZE = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [MEM_CELL_SIZE-1:0]   byte_in,
  input  logic                       byte_valid,
  output logic                       byte_ready,
  output logic                       wr_en,
  output logic [WORD_SIZE-1:0]       wr_addr,
  output logic [MEM_CELL_SIZE*4-1:0] wr_data,
  output logic                       cpu_hold,
  output logic                       done,
  output logic                       error
);

  localparam int          DW        = MEM_CELL_SIZE * 4;
  localparam logic [17:0] MEM_BYTES = 18'(MEM_SIZE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  // Handshake: a byte moves on a rising edge when byte_valid && byte_ready;
  // the source must hold byte_in/byte_valid until then.
  state_t           state_q, state_d;
  logic [15:0]      len_q, len_d;
  logic [15:0]      word_cnt_q, word_cnt_d;
  logic [1:0]       byte_idx_q, byte_idx_d;
  logic [DW-1:0]    asm_q, asm_d;
  logic             wr_en_q, wr_en_d;
  logic [WORD_SIZE-1:0] wr_addr_q, wr_addr_d;
  logic [DW-1:0]    wr_data_q, wr_data_d;
  logic             xfer;
  logic [17:0]      len_x4;

  assign byte_ready = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                      (state_q == S_DATA);
  assign xfer       = byte_valid && byte_ready;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    word_cnt_d = word_cnt_q;
    byte_idx_d = byte_idx_q;
    asm_d      = asm_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    len_x4     = 18'd0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_LEN_HI;
      end
      S_LEN_HI: begin
        if (xfer) begin
          len_d   = {byte_in[7:0], len_q[7:0]};
          state_d = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (xfer) begin
          len_d  = {len_q[15:8], byte_in[7:0]};
          // 18-bit byte count so 0xFFFF words cannot wrap under the limit
          len_x4 = {len_d, 2'b00};
          if (len_x4 > MEM_BYTES) begin
            state_d = S_ERR;
          end else if (len_d == 16'd0) begin
            state_d = S_DONE;
          end else begin
            word_cnt_d = 16'd0;
            byte_idx_d = 2'd0;
            state_d    = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (xfer) begin
          asm_d      = {asm_q[DW-MEM_CELL_SIZE-1:0], byte_in};
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            wr_en_d   = 1'b1;
            wr_addr_d = WORD_SIZE'({word_cnt_q, 2'b00});
            wr_data_d = asm_d;
            state_d   = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        word_cnt_d = word_cnt_q + 16'd1;
        state_d    = (word_cnt_d == len_q) ? S_DONE : S_DATA;
      end
      S_DONE, S_ERR: begin
        if (start) state_d = S_LEN_HI;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      len_q      <= 16'd0;
      word_cnt_q <= 16'd0;
      byte_idx_q <= 2'd0;
      asm_q      <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      word_cnt_q <= word_cnt_d;
      byte_idx_q <= byte_idx_d;
      asm_q      <= asm_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign cpu_hold = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done     = (state_q == S_DONE);
  assign error    = (state_q == S_ERR);

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: cycle table for the basic load, then directed
// sequences for gaps, capacity, zero length, reset mid-word and restart.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst, start, byte_valid;
  logic [7:0]  byte_in;
  logic        byte_ready, wr_en, cpu_hold, done, error;
  logic [31:0] wr_addr, wr_data;

  int n_vec    = 0;
  int n_err    = 0;
  int wr_count = 0;

  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];

  typedef struct packed {
    logic        rst;
    logic        start;
    logic        valid;
    logic [7:0]  b;
    logic [4:0]  exp_flags; // {byte_ready, wr_en, cpu_hold, done, error}
    logic [31:0] exp_addr;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[16];

  imem_loader #(.WORD_SIZE(32), .MEM_SIZE(1024), .MEM_CELL_SIZE(8)) dut (
    .clk(clk), .rst(rst), .start(start), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .cpu_hold(cpu_hold),
    .done(done), .error(error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance one cycle and score any write strobe seen after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (wr_en === 1'b1) begin
      wr_count++;
      check("ready_low_in_write", {31'b0, byte_ready}, 32'h0);
      if (exp_addr_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_write: got addr %h data %h expected no write",
                 wr_addr, wr_data);
      end else begin
        check("wr_addr", wr_addr, exp_addr_q.pop_front());
        check("wr_data", wr_data, exp_data_q.pop_front());
      end
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    logic got;
    int   n;
    repeat (gap) begin
      byte_valid = 1'b0;
      tick();
    end
    byte_in    = b;
    byte_valid = 1'b1;
    got        = 1'b0;
    n          = 0;
    while (!got && n < 20) begin
      got = byte_ready;
      tick();
      n++;
    end
    byte_valid = 1'b0;
    if (!got) check("byte_accept_timeout", {31'b0, got}, 32'h1);
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check(name, {31'b0, done}, 32'h1);
  endtask

  initial begin
    int base;
    rst = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_in = 8'h00;

    vecs[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 5'b00000, 32'h0, 32'h0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 8'h00, 5'b10100, 32'h0, 32'h0};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 8'h00, 5'b10100, 32'h0, 32'h0};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 8'h02, 5'b10100, 32'h0, 32'h0};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 8'h80, 5'b10100, 32'h0, 32'h0};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 8'h20, 5'b10100, 32'h0, 32'h0};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 8'h00, 5'b10100, 32'h0, 32'h0};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 8'h0A, 5'b01100, 32'h0, 32'h8020000A};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 8'h04, 5'b10100, 32'h0, 32'h8020000A};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 8'h04, 5'b10100, 32'h0, 32'h8020000A};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 8'h40, 5'b10100, 32'h0, 32'h8020000A};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 8'h08, 5'b10100, 32'h0, 32'h8020000A};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 8'h00, 5'b01100, 32'h4, 32'h04400800};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 8'h00, 5'b00010, 32'h4, 32'h04400800};
    vecs[14] = '{1'b0, 1'b1, 1'b0, 8'h00, 5'b10100, 32'h4, 32'h04400800};
    vecs[15] = '{1'b1, 1'b0, 1'b0, 8'h00, 5'b00000, 32'h0, 32'h0};

    // Basic load, one vector per cycle; byte 04 at vector 8 sits through WRITE.
    exp_addr_q.push_back(32'h0); exp_data_q.push_back(32'h8020000A);
    exp_addr_q.push_back(32'h4); exp_data_q.push_back(32'h04400800);
    for (int i = 0; i < 16; i++) begin
      rst = vecs[i].rst; start = vecs[i].start;
      byte_valid = vecs[i].valid; byte_in = vecs[i].b;
      tick();
      check($sformatf("vec%0d_flags", i),
            {27'b0, byte_ready, wr_en, cpu_hold, done, error},
            {27'b0, vecs[i].exp_flags});
      check($sformatf("vec%0d_addr", i), wr_addr, vecs[i].exp_addr);
      check($sformatf("vec%0d_data", i), wr_data, vecs[i].exp_data);
    end
    rst = 1'b0; start = 1'b0; byte_valid = 1'b0;
    check("basic_writes", wr_count, 32'd2);

    // Same stream with valid pattern 1,0,0,1,...
    base = wr_count;
    exp_addr_q.push_back(32'h0); exp_data_q.push_back(32'h8020000A);
    exp_addr_q.push_back(32'h4); exp_data_q.push_back(32'h04400800);
    pulse_start();
    begin
      logic [7:0] s [10];
      s = '{8'h00, 8'h02, 8'h80, 8'h20, 8'h00, 8'h0A, 8'h04, 8'h40, 8'h08, 8'h00};
      for (int k = 0; k < 10; k++) send_byte(s[k], (k % 2 == 1) ? 2 : 0);
    end
    wait_done("gaps_done");
    check("gaps_hold", {31'b0, cpu_hold}, 32'h0);
    check("gaps_writes", wr_count - base, 32'd2);
    check("gaps_queue_empty", exp_addr_q.size(), 32'd0);

    // Full capacity: 256 words, last at 1020.
    base = wr_count;
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    for (int w = 0; w < 256; w++) begin
      logic [7:0] b0, b1, b2, b3;
      b0 = 8'(w); b1 = 8'(w) ^ 8'h5A; b2 = ~8'(w); b3 = 8'(w + 1);
      exp_addr_q.push_back(32'(w * 4));
      exp_data_q.push_back({b0, b1, b2, b3});
      send_byte(b0, 0); send_byte(b1, 0); send_byte(b2, 0); send_byte(b3, 0);
    end
    check("cap_last_addr", wr_addr, 32'd1020);
    tick();
    check("cap_done", {31'b0, done}, 32'h1);
    check("cap_hold", {31'b0, cpu_hold}, 32'h0);
    check("cap_writes", wr_count - base, 32'd256);

    // Reset after 2 of 4 data bytes; a byte offered during reset is dropped.
    base = wr_count;
    pulse_start();
    send_byte(8'h00, 0); send_byte(8'h01, 0);
    send_byte(8'hDE, 0); send_byte(8'hAD, 0);
    rst = 1'b1; byte_valid = 1'b1; byte_in = 8'hBE;
    tick();
    rst = 1'b0; byte_valid = 1'b0;
    check("rst_flags", {27'b0, byte_ready, wr_en, cpu_hold, done, error}, 32'h0);
    check("rst_addr", wr_addr, 32'h0);
    check("rst_data", wr_data, 32'h0);
    repeat (3) tick();
    check("rst_no_write", wr_count - base, 32'd0);
    exp_addr_q.push_back(32'h0); exp_data_q.push_back(32'hDEADBEEF);
    pulse_start();
    send_byte(8'h00, 0); send_byte(8'h01, 0);
    send_byte(8'hDE, 0); send_byte(8'hAD, 0); send_byte(8'hBE, 0); send_byte(8'hEF, 0);
    wait_done("rst_reload_done");
    check("rst_reload_writes", wr_count - base, 32'd1);

    // Over capacity: 257 words.
    base = wr_count;
    pulse_start();
    send_byte(8'h01, 0); send_byte(8'h01, 0);
    check("err_flags", {27'b0, byte_ready, wr_en, cpu_hold, done, error},
          {27'b0, 5'b00101});
    byte_valid = 1'b1; byte_in = 8'h55;
    repeat (4) tick();
    byte_valid = 1'b0;
    check("err_sticky", {31'b0, error}, 32'h1);
    check("err_no_write", wr_count - base, 32'd0);

    // Zero length, starting from ERR.
    pulse_start();
    check("zero_err_cleared", {30'b0, error, byte_ready}, 32'h1);
    send_byte(8'h00, 0); send_byte(8'h00, 0);
    check("zero_done", {30'b0, done, cpu_hold}, 32'h2);
    check("zero_no_write", wr_count - base, 32'd0);

    // start pulsed mid-word is ignored; start in DONE begins a new load.
    base = wr_count;
    exp_addr_q.push_back(32'h0); exp_data_q.push_back(32'h11223344);
    exp_addr_q.push_back(32'h4); exp_data_q.push_back(32'h55667788);
    pulse_start();
    send_byte(8'h00, 0); send_byte(8'h02, 0);
    send_byte(8'h11, 0); send_byte(8'h22, 0);
    pulse_start();
    check("ignore_start_busy", {30'b0, byte_ready, cpu_hold}, 32'h3);
    send_byte(8'h33, 0); send_byte(8'h44, 0);
    send_byte(8'h55, 0); send_byte(8'h66, 0); send_byte(8'h77, 0); send_byte(8'h88, 0);
    tick();
    check("ignore_done", {31'b0, done}, 32'h1);
    check("ignore_writes", wr_count - base, 32'd2);
    pulse_start();
    check("restart_flags", {27'b0, byte_ready, wr_en, cpu_hold, done, error},
          {27'b0, 5'b10100});
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("final_queue_empty", exp_addr_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
